// File: rtl/somador_pkg.sv
// Shared types and helpers for the debounced key accumulator.
// The state encoding and the step-size bound are used by somador_chaves.
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        APPLY  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Largest step magnitude: every key pressed at once, 1 + 2 + ... + nkeys.
    function automatic int max_step(input int nkeys);
        return (nkeys * (nkeys + 1)) / 2;
    endfunction

endpackage

// File: rtl/somador_chaves_if.sv
// Key/accumulator bus of somador_chaves: raw key levels in, count and status out.
// The master drives the keys, and the slave (the accumulator) drives the results.
interface somador_chaves_if #(
    parameter int WIDTH = 8,
    parameter int NKEYS = 3
) ();

    logic [NKEYS-1:0] keys;
    logic             neg;
    logic             clr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] step;
    logic             ovf;
    logic             upd;
    logic             busy;

    modport master (
        output keys, neg, clr,
        input  acc, step, ovf, upd, busy
    );

    modport slave (
        input  keys, neg, clr,
        output acc, step, ovf, upd, busy
    );

endinterface

// File: rtl/sincronizador.sv
// Two-flop synchroniser for a bundle of asynchronous levels.
// Both stages clear to 0 on reset.
module sincronizador #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/somador_chaves.sv
// Debounced key-to-step encoder with a signed accumulator (wrap or saturate).
// Each settled press adds its signed step to acc exactly once.
module somador_chaves
    import somador_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NKEYS    = 3,
    parameter int DEBOUNCE = 4,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          rst,
    somador_chaves_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if (max_step(NKEYS) > (2 ** (WIDTH - 1)) - 1) begin : g_step_too_wide
        $fatal(1, "somador_chaves: NKEYS step magnitude does not fit in WIDTH-1 bits");
    end

    if (DEBOUNCE < 1) begin : g_bad_debounce
        $fatal(1, "somador_chaves: DEBOUNCE must be at least 1");
    end

    logic [NKEYS:0]   pat;
    logic             pressed;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [NKEYS:0]   cap, cap_n;
    logic             apply;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] step_n;
    logic [WIDTH:0]   sum;
    logic             ovfl;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] step;
    logic             ovf;
    logic             upd;
    logic             busy;

    sincronizador #(.W(NKEYS + 1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({bus.neg, bus.keys}),
        .q   (pat)
    );

    // A lone sign key carries no magnitude, so only the magnitude keys make a press.
    assign pressed = |pat[NKEYS-1:0];

    // FSM state, debounce count and captured pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cap   <= cap_n;
        end
    end

    // Next-state logic: settle on a stable pattern, apply once, wait for a clean release.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap;
        apply   = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    cap_n   = pat;
                    cnt_n   = CNT_ONE;
                    state_n = (DEBOUNCE == 1) ? APPLY : SETTLE;
                end else begin
                    cnt_n = '0;
                end
            end
            SETTLE: begin
                if (!pressed) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (pat != cap) begin
                    cap_n   = pat;
                    cnt_n   = CNT_ONE;
                    state_n = (DEBOUNCE == 1) ? APPLY : SETTLE;
                end else if (cnt == DB_LAST) begin
                    cnt_n   = cnt + CNT_ONE;
                    state_n = APPLY;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                cnt_n   = '0;
                state_n = HOLD;
            end
            HOLD: begin
                if (pressed) begin
                    cnt_n = '0;
                end else if (cnt == DB_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Signed step from the captured pattern and the wrap/saturate sum.
    always_comb begin
        mag = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (cap[i]) begin
                mag = mag + WIDTH'(i + 1);
            end else begin
                mag = mag;
            end
        end
        step_n = cap[NKEYS] ? (-mag) : mag;
        sum    = {acc[WIDTH-1], acc} + {step_n[WIDTH-1], step_n};
        // With sign-extended operands, bit WIDTH is the true sign of the sum.
        ovfl   = sum[WIDTH] ^ sum[WIDTH-1];
        if (ovfl && (SATURATE != 0)) begin
            result = sum[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            result = sum[WIDTH-1:0];
        end
    end

    // Registered outputs; clr overrides an update landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            step <= '0;
            ovf  <= 1'b0;
            upd  <= 1'b0;
            busy <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            upd  <= 1'b0;
            if (apply) begin
                step <= step_n;
            end else begin
                step <= step;
            end
            if (bus.clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (apply) begin
                acc <= result;
                upd <= 1'b1;
                if (ovfl) begin
                    ovf <= 1'b1;
                end else begin
                    ovf <= ovf;
                end
            end else begin
                acc <= acc;
                ovf <= ovf;
            end
        end
    end

    assign bus.acc  = acc;
    assign bus.step = step;
    assign bus.ovf  = ovf;
    assign bus.upd  = upd;
    assign bus.busy = busy;

endmodule

// File: tb/tb_somador_chaves.sv
// Directed bench for somador_chaves: a wrapping and a saturating instance share one stimulus.
module tb_somador_chaves;

    logic       clk;
    logic       rst;
    logic [2:0] keys;
    logic       neg;
    logic       clr;

    int passed;
    int total;
    int pw;
    int ps;
    int first;

    somador_chaves_if #(.WIDTH(8), .NKEYS(3)) ifw ();
    somador_chaves_if #(.WIDTH(8), .NKEYS(3)) ifs ();

    assign ifw.keys = keys;
    assign ifw.neg  = neg;
    assign ifw.clr  = clr;
    assign ifs.keys = keys;
    assign ifs.neg  = neg;
    assign ifs.clr  = clr;

    somador_chaves #(.WIDTH(8), .NKEYS(3), .DEBOUNCE(4), .SATURATE(0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    somador_chaves #(.WIDTH(8), .NKEYS(3), .DEBOUNCE(4), .SATURATE(1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Hold a pattern, release it, and count upd pulses on both instances.
    task automatic press(input logic [2:0] k, input logic n, input int hold,
                         output int cw, output int cs);
        cw   = 0;
        cs   = 0;
        keys = k;
        neg  = n;
        repeat (hold) begin
            tick();
            if (ifw.upd) cw++;
            if (ifs.upd) cs++;
        end
        keys = 3'b000;
        neg  = 1'b0;
        repeat (8) begin
            tick();
            if (ifw.upd) cw++;
            if (ifs.upd) cs++;
        end
    endtask

    initial begin
        int tw;
        int ts;
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        keys   = 3'b000;
        neg    = 1'b0;
        clr    = 1'b0;
        repeat (3) tick();
        chk("reset_acc",  {24'd0, ifw.acc},  32'h0);
        chk("reset_step", {24'd0, ifw.step}, 32'h0);
        chk("reset_ovf",  {31'd0, ifw.ovf},  32'h0);
        chk("reset_upd",  {31'd0, ifw.upd},  32'h0);
        chk("reset_busy", {31'd0, ifw.busy}, 32'h0);
        chk("reset_acc_sat", {24'd0, ifs.acc}, 32'h0);
        rst = 1'b0;
        tick();
        tick();

        // Single press: upd lands on the 7th tick (edge t+6), exactly once.
        keys  = 3'b001;
        pw    = 0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ifw.upd) begin
                pw++;
                if (first == 0) first = i;
            end
        end
        chk("single_upd_count", pw, 32'd1);
        chk("single_upd_edge", first, 32'd7);
        chk("single_acc",  {24'd0, ifw.acc},  32'h01);
        chk("single_step", {24'd0, ifw.step}, 32'h01);
        chk("single_busy_held", {31'd0, ifw.busy}, 32'h1);
        keys = 3'b000;
        repeat (6) tick();
        chk("release_busy_still", {31'd0, ifw.busy}, 32'h1);
        tick();
        chk("release_busy_fall", {31'd0, ifw.busy}, 32'h0);

        // Negative combo: 2+3 subtracted from 1.
        press(3'b110, 1'b1, 8, pw, ps);
        chk("neg_upd_count", pw, 32'd1);
        chk("neg_step", {24'd0, ifw.step}, 32'h0000_00FB);
        chk("neg_acc",  {24'd0, ifw.acc},  32'h0000_00FC);
        chk("neg_ovf",  {31'd0, ifw.ovf},  32'h0);

        // Bounce never settles; the following stable key 2 (worth 3) applies once.
        tw = 0;
        for (int c = 0; c < 3; c++) begin
            keys = 3'b001;
            tick(); if (ifw.upd) tw++;
            tick(); if (ifw.upd) tw++;
            keys = 3'b000;
            tick(); if (ifw.upd) tw++;
            tick(); if (ifw.upd) tw++;
        end
        press(3'b100, 1'b0, 8, pw, ps);
        chk("bounce_upd_count", tw + pw, 32'd1);
        chk("bounce_step", {24'd0, ifw.step}, 32'h03);
        chk("bounce_acc",  {24'd0, ifw.acc},  32'h0000_00FF);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_acc", {24'd0, ifw.acc}, 32'h0);
        chk("clr_acc_sat", {24'd0, ifs.acc}, 32'h0);

        // Build up to 126 with 21 presses of +6.
        tw = 0;
        ts = 0;
        for (int p = 0; p < 21; p++) begin
            press(3'b111, 1'b0, 8, pw, ps);
            tw += pw;
            ts += ps;
        end
        chk("build_upd_count", tw, 32'd21);
        chk("build_acc",     {24'd0, ifw.acc}, 32'h7E);
        chk("build_acc_sat", {24'd0, ifs.acc}, 32'h7E);
        chk("build_ovf",     {31'd0, ifw.ovf}, 32'h0);

        // 126 + 3: wraps to -127 or clamps to 127.
        press(3'b011, 1'b0, 8, pw, ps);
        chk("wrap_acc", {24'd0, ifw.acc}, 32'h81);
        chk("wrap_ovf", {31'd0, ifw.ovf}, 32'h1);
        chk("sat_acc",  {24'd0, ifs.acc}, 32'h7F);
        chk("sat_ovf",  {31'd0, ifs.ovf}, 32'h1);

        // -1 afterwards: no new overflow, the flag stays set.
        press(3'b001, 1'b1, 8, pw, ps);
        chk("sat_minus1_acc", {24'd0, ifs.acc}, 32'h7E);
        chk("sat_minus1_ovf", {31'd0, ifs.ovf}, 32'h1);
        chk("wrap_minus1_acc", {24'd0, ifw.acc}, 32'h80);
        chk("wrap_minus1_ovf", {31'd0, ifw.ovf}, 32'h1);
        chk("wrap_minus1_step", {24'd0, ifw.step}, 32'hFF);

        // clr raised so it is sampled by the edge that ends APPLY.
        keys = 3'b010;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("coll_acc",     {24'd0, ifw.acc},  32'h0);
        chk("coll_acc_sat", {24'd0, ifs.acc},  32'h0);
        chk("coll_ovf",     {31'd0, ifw.ovf},  32'h0);
        chk("coll_ovf_sat", {31'd0, ifs.ovf},  32'h0);
        chk("coll_upd",     {31'd0, ifw.upd},  32'h0);
        chk("coll_step",    {24'd0, ifw.step}, 32'h02);
        keys = 3'b000;
        repeat (8) tick();
        chk("coll_acc_after", {24'd0, ifw.acc}, 32'h0);

        press(3'b001, 1'b0, 8, pw, ps);
        chk("pre_rst_acc", {24'd0, ifw.acc}, 32'h01);

        // Reset during SETTLE with the key held.
        keys = 3'b100;
        repeat (4) tick();
        chk("settle_busy", {31'd0, ifw.busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_acc",  {24'd0, ifw.acc},  32'h0);
        chk("midrst_step", {24'd0, ifw.step}, 32'h0);
        chk("midrst_busy", {31'd0, ifw.busy}, 32'h0);
        chk("midrst_ovf",  {31'd0, ifw.ovf},  32'h0);
        chk("midrst_upd",  {31'd0, ifw.upd},  32'h0);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("postrst_upd_early", {31'd0, ifw.upd}, 32'h0);
        chk("postrst_acc_early", {24'd0, ifw.acc}, 32'h0);
        tick();
        chk("postrst_upd", {31'd0, ifw.upd},  32'h1);
        chk("postrst_acc", {24'd0, ifw.acc},  32'h03);
        chk("postrst_step", {24'd0, ifw.step}, 32'h03);
        press(3'b100, 1'b0, 4, pw, ps);
        chk("postrst_no_repeat", pw, 32'd0);
        chk("postrst_acc_final", {24'd0, ifs.acc}, 32'h03);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
